// File: rtl/fp_adder_param.sv
// +--------------------------------------------------------------------------+
// | fp_adder_param : handshaked IEEE-754 adder/subtractor, width-generic     |
// | Option macro   : FP_ADDER_SUBNORMAL_EN (gradual underflow when defined)  |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module fp_adder_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic [3:0]             flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int UW = EXP_W + MAN_W + 1;  // {exponent, hidden, fraction}
  localparam int ML = MAN_W + 4;          // hidden | fraction | guard | round | sticky
  localparam int EW = EXP_W + 2;          // signed working exponent
  localparam int LW = $clog2(ML + 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] EMAX = $signed({2'b00, {EXP_W{1'b1}}});
  localparam logic signed [EW-1:0] ONE  = $signed(EW'(1));
`ifdef FP_ADDER_SUBNORMAL_EN
  localparam bit SUBN_EN = 1'b1;
`else
  localparam bit SUBN_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
  state_t state;

  function automatic logic [UW-1:0] unpack(input logic [W-2:0] v);
    if (v[W-2:MAN_W] != '0) return {v[W-2:MAN_W], 1'b1, v[MAN_W-1:0]};
    else if (SUBN_EN)       return {EXP_W'(1), 1'b0, v[MAN_W-1:0]};
    else                    return '0;
  endfunction

  function automatic logic [LW-1:0] lzc(input logic [ML-1:0] v);
    logic [LW-1:0] n;
    logic          found;
    n = LW'(ML);
    found = 1'b0;
    for (int i = ML - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n = LW'(ML - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // capture-stage special-case resolution
  logic           w_sb, w_a_inf, w_a_nan, w_b_inf, w_b_nan, w_spec;
  logic [W-1:0]   w_spec_sum;
  logic [3:0]     w_spec_flags;
  always_comb begin
    w_sb    = b[W-1] ^ sub;
    w_a_inf = (&a[W-2:MAN_W]) && (a[MAN_W-1:0] == '0);
    w_a_nan = (&a[W-2:MAN_W]) && (a[MAN_W-1:0] != '0);
    w_b_inf = (&b[W-2:MAN_W]) && (b[MAN_W-1:0] == '0);
    w_b_nan = (&b[W-2:MAN_W]) && (b[MAN_W-1:0] != '0);
    w_spec       = 1'b1;
    w_spec_sum   = QNAN;
    w_spec_flags = 4'b0000;
    if (w_a_nan || w_b_nan) w_spec_flags = 4'b0000;
    else if (w_a_inf && w_b_inf && (a[W-1] != w_sb)) w_spec_flags = 4'b1000;
    else if (w_a_inf) w_spec_sum = a;
    else if (w_b_inf) w_spec_sum = {w_sb, b[W-2:0]};
    else w_spec = 1'b0;
  end

  logic           r_as, r_bs, r_spec, r_xs, r_sub_eff, r_zero, r_sign, r_tiny, r_inx;
  logic [UW-1:0]  r_au, r_bu;
  logic [W-1:0]   r_spec_sum;
  logic [3:0]     r_spec_flags;
  logic [EXP_W-1:0] r_xe;
  logic [ML-1:0]  r_xm, r_ym, r_nm;
  logic [ML:0]    r_sum;
  logic signed [EW-1:0] r_ne, r_re;
  logic [MAN_W:0] r_rm;

  // alignment: larger magnitude becomes x, y shifted right with sticky collapse
  logic          w_swap;
  logic [UW-1:0] w_xu, w_yu;
  logic [EXP_W-1:0] w_d;
  logic [ML-1:0] w_yext, w_mask, w_yal;
  always_comb begin
    w_swap = r_bu > r_au;
    w_xu   = w_swap ? r_bu : r_au;
    w_yu   = w_swap ? r_au : r_bu;
    w_d    = w_xu[UW-1:MAN_W+1] - w_yu[UW-1:MAN_W+1];
    w_yext = {w_yu[MAN_W:0], 3'b000};
    w_mask = ~({ML{1'b1}} << w_d);
    w_yal  = (w_yext >> w_d) | {{(ML-1){1'b0}}, |(w_yext & w_mask)};
  end

  // normalisation; with subnormals the left shift stops at exponent 1
  logic [LW-1:0] w_lz;
  logic signed [EW-1:0] w_e, w_lim, w_sh, w_ne;
  logic [ML-1:0] w_nm;
  logic          w_tiny;
  always_comb begin
    w_lz  = lzc(r_sum[ML-1:0]);
    w_e   = $signed({2'b00, r_xe});
    w_lim = w_e - ONE;
    w_sh  = $signed(EW'(w_lz));
    if (SUBN_EN && (w_sh > w_lim)) w_sh = w_lim;
    if (r_sum[ML]) begin
      w_nm = {r_sum[ML:2], r_sum[1] | r_sum[0]};
      w_ne = w_e + ONE;
    end else begin
      w_nm = r_sum[ML-1:0] << w_sh[LW-1:0];
      w_ne = w_e - w_sh;
    end
    w_tiny = SUBN_EN && (w_ne == ONE) && !w_nm[ML-1];
  end

  logic [MAN_W:0]   w_keep;
  logic [MAN_W+1:0] w_rnd;
  logic             w_up;
  always_comb begin
    w_keep = r_nm[ML-1:3];
    w_up   = r_nm[2] & (r_nm[1] | r_nm[0] | w_keep[0]);
    w_rnd  = {1'b0, w_keep} + {{(MAN_W+1){1'b0}}, w_up};
  end

  logic [W-1:0] w_res;
  logic [3:0]   w_res_flags;
  always_comb begin
    w_res       = '0;
    w_res_flags = 4'b0000;
    if (r_spec) begin
      w_res       = r_spec_sum;
      w_res_flags = r_spec_flags;
    end else if (r_zero) begin
      w_res = {r_sign, {(W-1){1'b0}}};
    end else if (r_re >= EMAX) begin
      w_res       = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_res_flags = 4'b0101;
    end else if (r_re < ONE) begin
      w_res       = {r_sign, {(W-1){1'b0}}};
      w_res_flags = 4'b0011;
    end else begin
      w_res       = {r_sign, (r_rm[MAN_W] ? r_re[EXP_W-1:0] : {EXP_W{1'b0}}), r_rm[MAN_W-1:0]};
      w_res_flags = {2'b00, r_tiny & r_inx, r_inx};
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= S_IDLE;  in_ready <= 1'b0;  out_valid <= 1'b0;
      sum <= '0;  flags <= '0;
      r_as <= 1'b0;  r_bs <= 1'b0;  r_au <= '0;  r_bu <= '0;
      r_spec <= 1'b0;  r_spec_sum <= '0;  r_spec_flags <= '0;
      r_xs <= 1'b0;  r_sub_eff <= 1'b0;  r_xe <= '0;  r_xm <= '0;  r_ym <= '0;
      r_sum <= '0;  r_nm <= '0;  r_ne <= '0;  r_zero <= 1'b0;  r_sign <= 1'b0;
      r_tiny <= 1'b0;  r_rm <= '0;  r_re <= '0;  r_inx <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready     <= 1'b0;
            r_as         <= a[W-1];
            r_bs         <= w_sb;
            r_au         <= unpack(a[W-2:0]);
            r_bu         <= unpack(b[W-2:0]);
            r_spec       <= w_spec;
            r_spec_sum   <= w_spec_sum;
            r_spec_flags <= w_spec_flags;
            state        <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_xs      <= w_swap ? r_bs : r_as;
          r_sub_eff <= r_as ^ r_bs;
          r_xe      <= w_xu[UW-1:MAN_W+1];
          r_xm      <= {w_xu[MAN_W:0], 3'b000};
          r_ym      <= w_yal;
          state     <= S_ADD;
        end
        S_ADD: begin
          r_sum <= r_sub_eff ? ({1'b0, r_xm} - {1'b0, r_ym}) : ({1'b0, r_xm} + {1'b0, r_ym});
          state <= S_NORM;
        end
        S_NORM: begin
          r_nm   <= w_nm;
          r_ne   <= w_ne;
          r_tiny <= w_tiny;
          r_zero <= (r_sum == '0);
          r_sign <= ((r_sum == '0) && r_sub_eff) ? 1'b0 : r_xs;
          state  <= S_ROUND;
        end
        S_ROUND: begin
          r_rm  <= w_rnd[MAN_W+1] ? w_rnd[MAN_W+1:1] : w_rnd[MAN_W:0];
          r_re  <= w_rnd[MAN_W+1] ? r_ne + ONE : r_ne;
          r_inx <= |r_nm[2:0];
          state <= S_DONE;
        end
        S_DONE: begin
          // first DONE cycle packs the result; it is then held until taken
          if (!out_valid) begin
            sum       <= w_res;
            flags     <= w_res_flags;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire
